// File: rtl/format_lock_ctrl.sv
`timescale 1ns/1ps
// format_lock_ctrl: sequences the VSYNC-period format detector. It restarts the
// detector, debounces its results into a confirmed format/lock pair, re-checks
// periodically or on request, and flags loss of signal after repeated timeouts.
//
// Handshake: the detector reports a result as a single-cycle det_valid with
// det_type alongside. det_valid is honoured only while waiting for a result and
// there is no back-pressure; format_changed is a one-cycle pulse that
// accompanies the first cycle of a newly confirmed format.
module format_lock_ctrl #(
    parameter int TIMEOUT_CYCLES = 8_000_000,
    parameter int RECHECK_CYCLES = 50_000_000,
    parameter int CONFIRM_COUNT  = 2,
    parameter int MAX_RETRIES    = 3
) (
    input  logic clk_in,
    input  logic rst,
    input  logic det_valid,
    input  logic det_type,
    input  logic force_recheck,
    output logic det_rst,
    output logic locked,
    output logic format_out,
    output logic format_changed,
    output logic no_signal
);

    localparam int TIMER_SPAN = (TIMEOUT_CYCLES > RECHECK_CYCLES) ? TIMEOUT_CYCLES : RECHECK_CYCLES;
    localparam int TW = (TIMER_SPAN > 1) ? $clog2(TIMER_SPAN) : 1;
    localparam int AW = (CONFIRM_COUNT > 0) ? $clog2(CONFIRM_COUNT + 1) : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] RECHECK_LAST = TW'(RECHECK_CYCLES - 1);
    localparam logic [AW-1:0] AGREE_DONE   = AW'(CONFIRM_COUNT);
    localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);

    typedef enum logic [1:0] {
        KICK = 2'd0,
        WAIT = 2'd1,
        EVAL = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic [RW-1:0] retries, retries_nx;
    logic [AW-1:0] agree, agree_nx, agree_eval;
    logic          cand, cand_nx;
    logic          cap, cap_nx;
    logic          locked_nx, format_nx, changed_nx, no_signal_nx, det_rst_nx;

    // Register the FSM state, the sequencing datapath and every output.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state          <= KICK;
            timer          <= '0;
            retries        <= '0;
            agree          <= '0;
            cand           <= 1'b0;
            cap            <= 1'b0;
            det_rst        <= 1'b1;
            locked         <= 1'b0;
            format_out     <= 1'b0;
            format_changed <= 1'b0;
            no_signal      <= 1'b0;
        end else begin
            state          <= state_nx;
            timer          <= timer_nx;
            retries        <= retries_nx;
            agree          <= agree_nx;
            cand           <= cand_nx;
            cap            <= cap_nx;
            det_rst        <= det_rst_nx;
            locked         <= locked_nx;
            format_out     <= format_nx;
            format_changed <= changed_nx;
            no_signal      <= no_signal_nx;
        end
    end

    // Next-state and next-output decisions for each phase of a detection attempt.
    always_comb begin
        state_nx     = state;
        timer_nx     = timer;
        retries_nx   = retries;
        agree_nx     = agree;
        agree_eval   = agree;
        cand_nx      = cand;
        cap_nx       = cap;
        locked_nx    = locked;
        format_nx    = format_out;
        no_signal_nx = no_signal;
        changed_nx   = 1'b0;

        case (state)
            KICK: begin
                timer_nx = '0;
                state_nx = WAIT;
            end

            WAIT: begin
                timer_nx = timer + TW'(1);
                // A result arriving on the last allowed cycle still counts.
                if (det_valid) begin
                    cap_nx   = det_type;
                    state_nx = EVAL;
                end else if (timer == TIMEOUT_LAST) begin
                    state_nx = KICK;
                    if (retries == RETRY_LAST) begin
                        locked_nx    = 1'b0;
                        no_signal_nx = 1'b1;
                        retries_nx   = '0;
                        agree_nx     = '0;
                    end else begin
                        retries_nx = retries + RW'(1);
                    end
                end
            end

            EVAL: begin
                if ((agree == '0) || (cap != cand)) begin
                    cand_nx    = cap;
                    agree_eval = AW'(1);
                end else begin
                    agree_eval = agree + AW'(1);
                end
                agree_nx   = agree_eval;
                retries_nx = '0;
                // HOLD measures its re-check interval from zero.
                timer_nx   = '0;
                if (agree_eval == AGREE_DONE) begin
                    changed_nx   = !locked || (cand_nx != format_out);
                    locked_nx    = 1'b1;
                    format_nx    = cand_nx;
                    no_signal_nx = 1'b0;
                    agree_nx     = '0;
                    state_nx     = HOLD;
                end else begin
                    state_nx = KICK;
                end
            end

            HOLD: begin
                timer_nx = timer + TW'(1);
                // Expiry and a forced request on the same cycle give one KICK.
                if ((timer == RECHECK_LAST) || force_recheck) begin
                    agree_nx = '0;
                    state_nx = KICK;
                end
            end

            default: begin
                state_nx = KICK;
            end
        endcase

        // The detector reset is high exactly while the FSM sits in KICK.
        det_rst_nx = (state_nx == KICK);
    end

endmodule
